// File: rtl/cc_tag_seq.sv
// Tag-way sequencer for the icache: power-on/flush init sweep, fill/snoop-invalidate
// arbitration into single tag operations, and per-way result collection into one ack.
module cc_tag_seq #(
   parameter int unsigned ADDR_WIDTH  = 7,
   parameter int unsigned ADDR_COUNT  = 128,
   parameter int unsigned PADDR_WIDTH = 37
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     init_req,
   input  logic                     fill_req,
   input  logic [PADDR_WIDTH-1:0]   fill_addr,
   output logic                     fill_ack,
   input  logic                     inv_req,
   input  logic [PADDR_WIDTH-1:0]   inv_addr,
   output logic                     inv_ack,
   output logic                     inv_hit,
   output logic                     expun_valid,
   output logic [PADDR_WIDTH-1:0]   expun_addr,
   output logic                     err_multi,
   output logic                     busy,
   output logic [PADDR_WIDTH-1:0]   tag_write_phys_addr,
   output logic                     tag_write_wen,
   output logic                     tag_invalidate,
   output logic                     tag_init,
   input  logic [7:0]               way_write_hit,
   input  logic [7:0]               way_exp_en,
   input  logic [8*PADDR_WIDTH-1:0] way_exp_addr
);

   typedef enum logic [2:0] {
      S_INIT, S_DRAIN, S_IDLE, S_ISSUE, S_WAIT, S_CHECK
   } state_e;

   typedef enum logic {OP_FILL, OP_INV} op_e;

   localparam logic [ADDR_WIDTH-1:0] CNT_LAST  = ADDR_WIDTH'(ADDR_COUNT - 1);
   localparam logic [ADDR_WIDTH-1:0] DRAIN_END = ADDR_WIDTH'(1);

   state_e                  state_q, state_d;
   op_e                     op_q, op_d;
   logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
   logic [PADDR_WIDTH-1:0]  addr_q, addr_d;
   logic                    init_pend_q, init_pend_d;

   logic [3:0]              hit_cnt;
   logic                    sel_exp;
   logic [PADDR_WIDTH-1:0]  sel_addr;

   // Tag arrays update on the falling edge, so this block does too.
   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_INIT;
         op_q        <= OP_FILL;
         cnt_q       <= '0;
         addr_q      <= '0;
         init_pend_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         init_pend_q <= init_pend_d;
      end
   end

   // Popcount of the way hits; with exactly one hit, sel_* refer to that way.
   always_comb begin
      hit_cnt  = '0;
      sel_exp  = 1'b0;
      sel_addr = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         if (way_write_hit[i]) begin
            hit_cnt  = hit_cnt + 4'd1;
            sel_exp  = way_exp_en[i];
            sel_addr = way_exp_addr[i*PADDR_WIDTH +: PADDR_WIDTH];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      init_pend_d = init_pend_q;

      fill_ack            = 1'b0;
      inv_ack             = 1'b0;
      inv_hit             = 1'b0;
      expun_valid         = 1'b0;
      expun_addr          = '0;
      err_multi           = 1'b0;
      busy                = (state_q != S_IDLE);
      tag_init            = (state_q == S_INIT);
      tag_write_wen       = (state_q == S_ISSUE) && (op_q == OP_FILL);
      tag_invalidate      = (state_q == S_ISSUE) && (op_q == OP_INV);
      tag_write_phys_addr = (state_q == S_INIT) ? PADDR_WIDTH'(cnt_q) : addr_q;

      if (state_q != S_IDLE && init_req) begin
         init_pend_d = 1'b1;
      end

      case (state_q)
         S_INIT: begin
            if (cnt_q == CNT_LAST) begin
               state_d = S_DRAIN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + ADDR_WIDTH'(1);
            end
         end
         S_DRAIN: begin
            if (cnt_q == DRAIN_END) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + ADDR_WIDTH'(1);
            end
         end
         S_IDLE: begin
            if (init_req || init_pend_q) begin
               state_d     = S_INIT;
               cnt_d       = '0;
               init_pend_d = 1'b0;
            end else if (inv_req) begin
               state_d = S_ISSUE;
               op_d    = OP_INV;
               addr_d  = inv_addr;
            end else if (fill_req) begin
               state_d = S_ISSUE;
               op_d    = OP_FILL;
               addr_d  = fill_addr;
            end
         end
         S_ISSUE: state_d = S_WAIT;
         S_WAIT:  state_d = S_CHECK;
         S_CHECK: begin
            state_d = S_IDLE;
            if (op_q == OP_FILL) begin
               fill_ack  = 1'b1;
               err_multi = (hit_cnt != 4'd1);
               if (hit_cnt == 4'd1 && sel_exp) begin
                  expun_valid = 1'b1;
                  expun_addr  = sel_addr;
               end
            end else begin
               inv_ack   = 1'b1;
               inv_hit   = (hit_cnt != 4'd0);
               err_multi = (hit_cnt > 4'd1);
            end
         end
         default: state_d = S_INIT;
      endcase
   end

endmodule

// File: tb/tb_cc_tag_seq.sv
// Scoreboard bench for cc_tag_seq: a way-response model answers tag strobes and
// expected acknowledges are queued at request time and compared when acks appear.
module tb_cc_tag_seq;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                init_req = 1'b0;
   logic                fill_req = 1'b0;
   logic                inv_req = 1'b0;
   logic [36:0]         fill_addr = '0;
   logic [36:0]         inv_addr = '0;
   logic [7:0]          way_write_hit = '0;
   logic [7:0]          way_exp_en = '0;
   logic [8*37-1:0]     way_exp_addr = '0;

   logic                fill_ack, inv_ack, inv_hit, expun_valid, err_multi, busy;
   logic [36:0]         expun_addr, tag_write_phys_addr;
   logic                tag_write_wen, tag_invalidate, tag_init;

   int unsigned n_chk = 0;
   int unsigned n_bad = 0;
   int unsigned cyc = 0;

   typedef struct {
      logic [36:0]     addr;
      int unsigned     cyc;
      logic [7:0]      hit;
      logic [7:0]      en;
      logic [8*37-1:0] ea;
   } resp_t;

   typedef struct {
      bit          inv;
      bit          hit;
      bit          ev;
      logic [36:0] ea;
      bit          err;
      int unsigned cyc;
   } ack_t;

   resp_t fill_q[$];
   resp_t inv_q[$];
   ack_t  ack_q[$];

   cc_tag_seq #(.ADDR_WIDTH(7), .ADDR_COUNT(128), .PADDR_WIDTH(37)) dut (
      .clk(clk), .rst(rst), .init_req(init_req),
      .fill_req(fill_req), .fill_addr(fill_addr), .fill_ack(fill_ack),
      .inv_req(inv_req), .inv_addr(inv_addr), .inv_ack(inv_ack), .inv_hit(inv_hit),
      .expun_valid(expun_valid), .expun_addr(expun_addr), .err_multi(err_multi),
      .busy(busy), .tag_write_phys_addr(tag_write_phys_addr),
      .tag_write_wen(tag_write_wen), .tag_invalidate(tag_invalidate), .tag_init(tag_init),
      .way_write_hit(way_write_hit), .way_exp_en(way_exp_en), .way_exp_addr(way_exp_addr)
   );

   always #5 clk = ~clk;

   // Cycle index advances on the active (falling) edge; read on the rising edge.
   always @(negedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [8*37-1:0] mk_ea(input int unsigned w, input logic [36:0] a);
      logic [8*37-1:0] r;
      for (int unsigned k = 0; k < 8; k++) r[k*37 +: 37] = 37'h1000 + 37'(k);
      r[w*37 +: 37] = a;
      return r;
   endfunction

   task automatic push_resp(input bit inv, input logic [36:0] a, input int unsigned c,
                            input logic [7:0] h, input logic [7:0] e, input logic [8*37-1:0] ea);
      resp_t r;
      r.addr = a; r.cyc = c; r.hit = h; r.en = e; r.ea = ea;
      if (inv) inv_q.push_back(r);
      else     fill_q.push_back(r);
   endtask

   task automatic push_ack(input bit inv, input bit hit, input bit ev, input logic [36:0] ea,
                           input bit err, input int unsigned c);
      ack_t a;
      a.inv = inv; a.hit = hit; a.ev = ev; a.ea = ea; a.err = err; a.cyc = c;
      ack_q.push_back(a);
   endtask

   // Requester behaviour: drop each req on the cycle its ack is seen.
   task automatic wait_reqs(input int unsigned budget);
      for (int unsigned k = 0; k < budget && (fill_req || inv_req); k++) begin
         @(posedge clk);
         if (inv_ack)  inv_req = 1'b0;
         if (fill_ack) fill_req = 1'b0;
      end
      chk("req_timeout", {62'd0, fill_req, inv_req}, 64'd0);
      fill_req = 1'b0;
      inv_req  = 1'b0;
      @(posedge clk);
   endtask

   task automatic wait_idle(input int unsigned budget);
      for (int unsigned k = 0; k < budget && busy; k++) @(posedge clk);
      chk("flush_done", busy, 0);
   endtask

   task automatic do_single(input bit inv, input logic [36:0] a, input logic [7:0] h,
                            input logic [7:0] e, input logic [8*37-1:0] ea,
                            input bit xh, input bit xv, input logic [36:0] xa, input bit xe);
      int unsigned c;
      c = cyc;
      push_resp(inv, a, c + 1, h, e, ea);
      push_ack(inv, xh, xv, xa, xe, c + 3);
      if (inv) begin inv_addr = a; inv_req = 1'b1; end
      else     begin fill_addr = a; fill_req = 1'b1; end
      wait_reqs(20);
   endtask

   task automatic chk_reset_vals();
      chk("rst_fill_ack", fill_ack, 0);
      chk("rst_inv_ack", inv_ack, 0);
      chk("rst_inv_hit", inv_hit, 0);
      chk("rst_expun_valid", expun_valid, 0);
      chk("rst_err_multi", err_multi, 0);
      chk("rst_expun_addr", expun_addr, 0);
      chk("rst_wen", tag_write_wen, 0);
      chk("rst_inval", tag_invalidate, 0);
      chk("rst_tag_init", tag_init, 1);
      chk("rst_addr", tag_write_phys_addr, 0);
      chk("rst_busy", busy, 1);
   endtask

   // Way model: answer each tag strobe with the queued per-way response.
   always @(posedge clk) begin
      resp_t       r;
      int unsigned qs;
      if (!rst && (tag_write_wen || tag_invalidate)) begin
         chk("strobe_excl", tag_write_wen & tag_invalidate, 0);
         qs = tag_write_wen ? fill_q.size() : inv_q.size();
         if (qs == 0) begin
            chk("strobe_unexp", qs, 1);
         end else begin
            if (tag_write_wen) r = fill_q.pop_front();
            else               r = inv_q.pop_front();
            chk("strobe_addr", tag_write_phys_addr, r.addr);
            chk("strobe_cyc", cyc, r.cyc);
            way_write_hit = r.hit;
            way_exp_en    = r.en;
            way_exp_addr  = r.ea;
         end
      end
   end

   always @(posedge clk) begin
      ack_t a;
      if (!rst) begin
         if (fill_ack || inv_ack) begin
            if (ack_q.size() == 0) begin
               chk("ack_unexp", ack_q.size(), 1);
            end else begin
               a = ack_q.pop_front();
               chk("ack_inv", inv_ack, a.inv);
               chk("ack_fill", fill_ack, !a.inv);
               chk("ack_cyc", cyc, a.cyc);
               chk("inv_hit", inv_hit, a.hit);
               chk("expun_valid", expun_valid, a.ev);
               chk("expun_addr", expun_addr, a.ea);
               chk("err_multi", err_multi, a.err);
            end
         end else begin
            chk("err_noack", err_multi, 0);
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog expired got=running exp=finished");
      $display("test done: total=%0d bad=%0d", n_chk, n_bad + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned c;

      repeat (3) @(posedge clk);
      chk_reset_vals();
      rst = 1'b0;
      for (int i = 0; i < 128; i++) begin
         chk("init_on", tag_init, 1);
         chk("init_addr", tag_write_phys_addr, 64'(i));
         @(posedge clk);
      end
      chk("drain1_init", tag_init, 0);
      chk("drain1_busy", busy, 1);
      @(posedge clk);
      chk("drain2_init", tag_init, 0);
      chk("drain2_busy", busy, 1);
      @(posedge clk);
      chk("idle_busy", busy, 0);

      do_single(1'b0, 37'h12345, 8'h08, 8'h09, mk_ea(3, 37'hABC), 1'b0, 1'b1, 37'hABC, 1'b0);
      do_single(1'b1, 37'h777, 8'h00, 8'h00, mk_ea(0, 37'h5), 1'b0, 1'b0, 37'h0, 1'b0);
      do_single(1'b1, 37'h777, 8'h20, 8'h20, mk_ea(5, 37'h999), 1'b1, 1'b0, 37'h0, 1'b0);
      do_single(1'b0, 37'h2222, 8'h12, 8'h12, mk_ea(4, 37'h333), 1'b0, 1'b0, 37'h0, 1'b1);
      do_single(1'b1, 37'h3333, 8'h03, 8'h03, mk_ea(1, 37'h444), 1'b1, 1'b0, 37'h0, 1'b1);
      do_single(1'b0, 37'h1F_FFFF_FFFF, 8'h80, 8'h80, mk_ea(7, 37'h1F_FFFF_FFFF),
                1'b0, 1'b1, 37'h1F_FFFF_FFFF, 1'b0);
      do_single(1'b0, 37'h4444, 8'h01, 8'h00, mk_ea(0, 37'h666), 1'b0, 1'b0, 37'h0, 1'b0);
      do_single(1'b0, 37'h5555, 8'h00, 8'hFF, mk_ea(2, 37'h888), 1'b0, 1'b0, 37'h0, 1'b1);

      // Simultaneous requests: invalidate first, fill four cycles later.
      c = cyc;
      push_resp(1'b1, 37'h500, c + 1, 8'h00, 8'h00, mk_ea(0, 37'h1));
      push_resp(1'b0, 37'h600, c + 5, 8'h01, 8'h00, mk_ea(0, 37'h2));
      push_ack(1'b1, 1'b0, 1'b0, 37'h0, 1'b0, c + 3);
      push_ack(1'b0, 1'b0, 1'b0, 37'h0, 1'b0, c + 7);
      inv_addr = 37'h500;  inv_req = 1'b1;
      fill_addr = 37'h600; fill_req = 1'b1;
      wait_reqs(20);

      // init_req during ISSUE: fill still acks, sweep starts after one IDLE cycle.
      c = cyc;
      push_resp(1'b0, 37'h4321, c + 1, 8'h04, 8'h00, mk_ea(2, 37'h55));
      push_ack(1'b0, 1'b0, 1'b0, 37'h0, 1'b0, c + 3);
      fill_addr = 37'h4321; fill_req = 1'b1;
      @(posedge clk);
      init_req = 1'b1;
      @(posedge clk);
      init_req = 1'b0;
      @(posedge clk);
      chk("pend_fill_ack", fill_ack, 1);
      fill_req = 1'b0;
      @(posedge clk);
      chk("pend_idle_busy", busy, 0);
      chk("pend_idle_init", tag_init, 0);
      @(posedge clk);
      chk("pend_init_on", tag_init, 1);
      chk("pend_init_addr", tag_write_phys_addr, 0);
      wait_idle(300);
      @(posedge clk);

      // Reset during WAIT: op dropped without ack, outputs at reset values.
      c = cyc;
      push_resp(1'b0, 37'h2468, c + 1, 8'h01, 8'h01, mk_ea(0, 37'h77));
      fill_addr = 37'h2468; fill_req = 1'b1;
      @(posedge clk);
      @(posedge clk);
      rst = 1'b1;
      fill_req = 1'b0;
      #1;
      chk_reset_vals();
      @(posedge clk);
      chk("rst_no_ack", fill_ack, 0);
      @(posedge clk);
      rst = 1'b0;
      wait_idle(300);
      @(posedge clk);

      do_single(1'b0, 37'h13579, 8'h40, 8'h40, mk_ea(6, 37'h2222), 1'b0, 1'b1, 37'h2222, 1'b0);

      chk("sb_left", ack_q.size(), 0);
      chk("resp_left", fill_q.size() + inv_q.size(), 0);
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
